// File: rtl/sgm_path_aggregator_pkg.sv
// Shared constants and helpers for the left-to-right SGM path aggregator.
// Costs are unsigned; intermediates carry two guard bits above COST_W.
package sgm_path_aggregator_pkg;

    localparam int NDISP  = 108;
    localparam int COST_W = 8;
    localparam int DIM_W  = 10;
    localparam int DEF_P1 = 10;
    localparam int DEF_P2 = 150;
    localparam int AW     = COST_W + 2;
    localparam int VEC_W  = NDISP * COST_W;

    localparam logic [COST_W-1:0] COST_MAX = '1;

    function automatic logic [COST_W-1:0] get_elem(input logic [VEC_W-1:0] v, input int unsigned d);
        return v[d*COST_W +: COST_W];
    endfunction

    // Both operands stay well inside AW bits, so the sum cannot wrap before clamping.
    function automatic logic [COST_W-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] s;
        s = a + b;
        return (s > AW'(COST_MAX)) ? COST_MAX : s[COST_W-1:0];
    endfunction

endpackage

// File: rtl/sgm_path_aggregator_cost_min_tree.sv
// Pipelined minimum over NDISP costs: 4:1 reduction (two comparator levels) per stage.
// Four register stages; the output is loaded only for a valid input and held otherwise.
module sgm_path_aggregator_cost_min_tree
    import sgm_path_aggregator_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [VEC_W-1:0]  vec_i,
    input  logic              vld_i,
    output logic [COST_W-1:0] min_o
);

    localparam int NPAD = 256;

    logic [COST_W-1:0] leaf [NPAD];
    logic [COST_W-1:0] l1_d [64];
    logic [COST_W-1:0] l1_q [64];
    logic [COST_W-1:0] l2_d [16];
    logic [COST_W-1:0] l2_q [16];
    logic [COST_W-1:0] l3_d [4];
    logic [COST_W-1:0] l3_q [4];
    logic [COST_W-1:0] l4_d;
    logic [COST_W-1:0] min_q;
    logic [2:0]        vld_q;

    function automatic logic [COST_W-1:0] min2(input logic [COST_W-1:0] a, input logic [COST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [COST_W-1:0] min4(input logic [COST_W-1:0] a, input logic [COST_W-1:0] b,
                                               input logic [COST_W-1:0] c, input logic [COST_W-1:0] d);
        return min2(min2(a, b), min2(c, d));
    endfunction

    // Unused leaves are padded with the largest cost so they never win.
    for (genvar i = 0; i < NPAD; i++) begin : g_leaf
        if (i < NDISP) begin : g_real
            assign leaf[i] = vec_i[i*COST_W +: COST_W];
        end else begin : g_pad
            assign leaf[i] = COST_MAX;
        end
    end

    always_comb begin
        for (int i = 0; i < 64; i++) l1_d[i] = min4(leaf[4*i], leaf[4*i+1], leaf[4*i+2], leaf[4*i+3]);
        for (int i = 0; i < 16; i++) l2_d[i] = min4(l1_q[4*i], l1_q[4*i+1], l1_q[4*i+2], l1_q[4*i+3]);
        for (int i = 0; i < 4; i++)  l3_d[i] = min4(l2_q[4*i], l2_q[4*i+1], l2_q[4*i+2], l2_q[4*i+3]);
        l4_d = min4(l3_q[0], l3_q[1], l3_q[2], l3_q[3]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 64; i++) l1_q[i] <= '0;
            for (int i = 0; i < 16; i++) l2_q[i] <= '0;
            for (int i = 0; i < 4; i++)  l3_q[i] <= '0;
            vld_q <= '0;
            min_q <= '0;
        end else begin
            l1_q  <= l1_d;
            l2_q  <= l2_d;
            l3_q  <= l3_d;
            vld_q <= {vld_q[1:0], vld_i};
            if (vld_q[2]) begin
                min_q <= l4_d;
            end
        end
    end

    assign min_o = min_q;

endmodule

// File: rtl/sgm_path_aggregator.sv
// Left-to-right SGM path cost aggregation: one pixel cost vector in, aggregated vector out.
// valid pulses 3 cycles after acceptance; ready stays low until the path minimum is updated.
module sgm_path_aggregator
    import sgm_path_aggregator_pkg::*;
#(
    parameter int P1 = DEF_P1,
    parameter int P2 = DEF_P2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [VEC_W-1:0]  cost_init,
    input  logic [DIM_W-1:0]  row,
    input  logic [DIM_W-1:0]  col,
    output logic              ready,
    output logic [VEC_W-1:0]  cost_aggr,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic              valid,
    output logic [COST_W-1:0] min_aggr
);

    localparam logic [3:0] BUSY_CYC = 4'd7;

    logic             accept;
    logic [3:0]       busy_q, busy_d;

    logic             cap_vld_q, cap_first_q;
    logic [VEC_W-1:0] cap_cost_q;
    logic [DIM_W-1:0] cap_row_q, cap_col_q;

    logic             s1_vld_q, s1_first_q;
    logic [VEC_W-1:0] s1_cost_q;
    logic [DIM_W-1:0] s1_row_q, s1_col_q;
    logic [AW-1:0]    s1_min_q [NDISP];
    logic [AW-1:0]    cand_min [NDISP];

    logic             s2_vld_q;
    logic [VEC_W-1:0] s2_res_q, s2_res_d;
    logic [DIM_W-1:0] s2_row_q, s2_col_q;

    logic             vld_q;
    logic [VEC_W-1:0] aggr_q;
    logic [DIM_W-1:0] orow_q, ocol_q;
    logic [COST_W-1:0] m_w;

    assign ready  = (busy_q == '0);
    assign accept = en & ready;

    // The busy window covers the full pipeline plus the min tree, so m is current for the next pixel.
    always_comb begin
        busy_d = busy_q;
        if (accept) begin
            busy_d = BUSY_CYC;
        end else if (busy_q != '0) begin
            busy_d = busy_q - 4'd1;
        end
    end

    // The output register doubles as the previous-pixel vector Lp; m comes from the held tree output.
    for (genvar d = 0; d < NDISP; d++) begin : g_d
        logic [AW-1:0] self_c, lo_c, hi_c, pen_c, m01, m23, diff;

        assign self_c = AW'(get_elem(aggr_q, d));
        assign pen_c  = AW'(m_w) + AW'(P2);

        if (d > 0) begin : g_lo
            assign lo_c = AW'(get_elem(aggr_q, d - 1)) + AW'(P1);
        end else begin : g_lo_none
            assign lo_c = '1;
        end

        if (d < NDISP - 1) begin : g_hi
            assign hi_c = AW'(get_elem(aggr_q, d + 1)) + AW'(P1);
        end else begin : g_hi_none
            assign hi_c = '1;
        end

        assign m01         = (self_c < lo_c) ? self_c : lo_c;
        assign m23         = (hi_c < pen_c) ? hi_c : pen_c;
        assign cand_min[d] = (m01 < m23) ? m01 : m23;

        assign diff = s1_min_q[d] - AW'(m_w);
        assign s2_res_d[d*COST_W +: COST_W] = s1_first_q ? get_elem(s1_cost_q, d)
                                                         : sat_add(AW'(get_elem(s1_cost_q, d)), diff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            cap_vld_q   <= 1'b0;
            cap_first_q <= 1'b0;
            cap_cost_q  <= '0;
            cap_row_q   <= '0;
            cap_col_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_cost_q   <= '0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            for (int i = 0; i < NDISP; i++) s1_min_q[i] <= '0;
            s2_vld_q    <= 1'b0;
            s2_res_q    <= '0;
            s2_row_q    <= '0;
            s2_col_q    <= '0;
            vld_q       <= 1'b0;
            aggr_q      <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            cap_vld_q <= accept;
            if (accept) begin
                cap_first_q <= (col == '0);
                cap_cost_q  <= cost_init;
                cap_row_q   <= row;
                cap_col_q   <= col;
            end
            s1_vld_q   <= cap_vld_q;
            s1_first_q <= cap_first_q;
            s1_cost_q  <= cap_cost_q;
            s1_row_q   <= cap_row_q;
            s1_col_q   <= cap_col_q;
            s1_min_q   <= cand_min;
            s2_vld_q   <= s1_vld_q;
            s2_res_q   <= s2_res_d;
            s2_row_q   <= s1_row_q;
            s2_col_q   <= s1_col_q;
            vld_q      <= s2_vld_q;
            if (s2_vld_q) begin
                aggr_q <= s2_res_q;
                orow_q <= s2_row_q;
                ocol_q <= s2_col_q;
            end
        end
    end

    sgm_path_aggregator_cost_min_tree u_min_tree (
        .clk_i  (clk),
        .rst_ni (rst),
        .vec_i  (aggr_q),
        .vld_i  (vld_q),
        .min_o  (m_w)
    );

    assign cost_aggr = aggr_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;
    assign valid     = vld_q;
    assign min_aggr  = m_w;

endmodule

// File: tb/tb_sgm_path_aggregator.sv
// Randomised scoreboard bench for sgm_path_aggregator with a behavioural SGM path model.
module tb_sgm_path_aggregator;
    import sgm_path_aggregator_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [VEC_W-1:0]  cost_init;
    logic [DIM_W-1:0]  row, col;
    logic              ready;
    logic [VEC_W-1:0]  cost_aggr;
    logic [DIM_W-1:0]  out_row, out_col;
    logic              valid;
    logic [COST_W-1:0] min_aggr;

    typedef struct {
        logic [VEC_W-1:0]  cost;
        int                row;
        int                col;
        int                mn;
    } exp_t;

    typedef struct {
        int due;
        int mn;
    } mexp_t;

    exp_t  exp_q[$];
    mexp_t mexp_q[$];
    exp_t  mon_e;
    mexp_t mon_m;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int pushed   = 0;
    int prev_l[NDISP];
    int prev_m   = 0;

    sgm_path_aggregator dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cost_init (cost_init),
        .row       (row),
        .col       (col),
        .ready     (ready),
        .cost_aggr (cost_aggr),
        .out_row   (out_row),
        .out_col   (out_col),
        .valid     (valid),
        .min_aggr  (min_aggr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] expv);
        int bad;
        bad = -1;
        n_checks++;
        for (int d = NDISP - 1; d >= 0; d--) begin
            if (act[d*COST_W +: COST_W] != expv[d*COST_W +: COST_W]) bad = d;
        end
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: element %0d got %0d, expected %0d", name, bad,
                     act[bad*COST_W +: COST_W], expv[bad*COST_W +: COST_W]);
        end
    endtask

    function automatic logic [VEC_W-1:0] fill(input int val);
        logic [VEC_W-1:0] v;
        for (int d = 0; d < NDISP; d++) v[d*COST_W +: COST_W] = COST_W'(val);
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec(input int lo, input int hi);
        logic [VEC_W-1:0] v;
        for (int d = 0; d < NDISP; d++) v[d*COST_W +: COST_W] = COST_W'($urandom_range(hi, lo));
        return v;
    endfunction

    function automatic int elem(input logic [VEC_W-1:0] v, input int d);
        return int'(v[d*COST_W +: COST_W]);
    endfunction

    // Issue one pixel once ready, updating the path model and the scoreboard.
    task automatic issue(input logic [VEC_W-1:0] c, input int r, input int cl);
        exp_t e;
        int   nxt[NDISP];
        int   w, best, v, mn;
        w = 0;
        while (!ready && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", int'(ready), 1);
        mn = 1 << 30;
        for (int d = 0; d < NDISP; d++) begin
            if (cl == 0) begin
                v = elem(c, d);
            end else begin
                best = prev_l[d];
                if (d > 0 && prev_l[d-1] + DEF_P1 < best) best = prev_l[d-1] + DEF_P1;
                if (d < NDISP - 1 && prev_l[d+1] + DEF_P1 < best) best = prev_l[d+1] + DEF_P1;
                if (prev_m + DEF_P2 < best) best = prev_m + DEF_P2;
                v = elem(c, d) + best - prev_m;
                if (v > 255) v = 255;
            end
            nxt[d] = v;
            e.cost[d*COST_W +: COST_W] = COST_W'(v);
            if (v < mn) mn = v;
        end
        prev_l = nxt;
        prev_m = mn;
        e.row  = r;
        e.col  = cl;
        e.mn   = mn;
        exp_q.push_back(e);
        pushed++;
        en        = 1'b1;
        cost_init = c;
        row       = DIM_W'(r);
        col       = DIM_W'(cl);
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            if (valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_vec("cost_aggr", cost_aggr, mon_e.cost);
                    chk("out_row", int'(out_row), mon_e.row);
                    chk("out_col", int'(out_col), mon_e.col);
                    mexp_q.push_back('{due: cyc + 4, mn: mon_e.mn});
                end
            end
            if (mexp_q.size() > 0 && mexp_q[0].due == cyc) begin
                mon_m = mexp_q.pop_front();
                chk("min_aggr", int'(min_aggr), mon_m.mn);
            end
        end
    end

    initial begin
        logic [VEC_W-1:0] v;
        int p0;
        for (int d = 0; d < NDISP; d++) prev_l[d] = 0;
        rst = 1'b0; en = 1'b0; cost_init = '0; row = '0; col = '0;
        wait_cycles(3);
        chk("rst_ready", int'(ready), 1);
        chk("rst_valid", int'(valid), 0);
        chk("rst_min", int'(min_aggr), 0);
        chk_vec("rst_aggr", cost_aggr, '0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // col 0 start: output equals input, exact latency and min timing.
        v = fill(32);
        v[5*COST_W +: COST_W] = 8'h05;
        issue(v, 3, 0);
        wait_cycles(2);
        chk("lat_not_early", int'(valid), 0);
        wait_cycles(1);
        chk("lat_valid", int'(valid), 1);
        chk_vec("col0_passthru", cost_aggr, v);
        wait_cycles(3);
        chk("ready_low_e6", int'(ready), 0);
        wait_cycles(1);
        chk("min_e7", int'(min_aggr), 5);
        chk("ready_e7", int'(ready), 1);

        // Next pixel with zero costs: neighbour/penalty recurrence.
        issue(fill(0), 3, 1);
        wait_cycles(3);
        chk("t3_L5", elem(cost_aggr, 5), 8'h00);
        chk("t3_L4", elem(cost_aggr, 4), 8'h0A);
        chk("t3_L6", elem(cost_aggr, 6), 8'h0A);
        chk("t3_L0", elem(cost_aggr, 0), 8'h1B);
        chk("t3_L107", elem(cost_aggr, NDISP - 1), 8'h1B);
        wait_cycles(4);
        chk("t3_min", int'(min_aggr), 0);

        // Saturation.
        v = fill(255);
        v[7:0] = 8'h00;
        issue(v, 4, 0);
        issue(fill(255), 4, 1);
        wait_cycles(3);
        chk_vec("sat_all_ff", cost_aggr, fill(255));

        // en while busy is dropped.
        p0 = pulses;
        issue(rand_vec(0, 60), 5, 2);
        wait_cycles(3);
        chk("drop_ready_low", int'(ready), 0);
        en = 1'b1; cost_init = fill(7); row = DIM_W'(5); col = DIM_W'(3);
        @(posedge clk); #1;
        en = 1'b0;
        wait_cycles(14);
        chk("drop_one_pulse", pulses - p0, 1);

        // Reset with a pixel in flight.
        issue(rand_vec(0, 255), 6, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        mexp_q.delete();
        pushed = pulses;
        for (int d = 0; d < NDISP; d++) prev_l[d] = 0;
        prev_m = 0;
        #1;
        chk("mid_rst_ready", int'(ready), 1);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_min", int'(min_aggr), 0);
        chk("mid_rst_row", int'(out_row), 0);
        chk("mid_rst_col", int'(out_col), 0);
        chk_vec("mid_rst_aggr", cost_aggr, '0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        p0 = pulses;
        wait_cycles(12);
        chk("no_valid_after_rst", pulses - p0, 0);

        // Frame stream: row 0 at 13-cycle spacing, row 1 back-to-back, then wrap.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 400; c++) begin
                case ($urandom_range(2, 0))
                    0:       v = rand_vec(0, 40);
                    1:       v = rand_vec(0, 255);
                    default: v = rand_vec(180, 255);
                endcase
                issue(v, r, c);
                if (r == 0) wait_cycles(12);
            end
        end
        v = rand_vec(0, 255);
        issue(v, 0, 0);
        wait_cycles(3);
        chk_vec("wrap_col0", cost_aggr, v);

        wait_cycles(20);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("mexp_q_empty", mexp_q.size(), 0);
        chk("pulse_count", pulses, pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
